// File: rtl/if_id_pipe_reg_pkg.sv
// Shared RISC-V front-end types: pipe occupancy states, canonical NOP and the
// fetch packet carried from IF to ID.
package rv_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_e;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;  // addi x0,x0,0
  localparam int          RV_XLEN = 32;
  localparam int          RV_ILEN = 32;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// IF->ID handshake bundle. The pipe register is the slave; fetch/decode
// (or a testbench) hold the master side.
interface if_id_pipe_reg_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_inst;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_inst;
  logic [1:0]      id_occ;

  modport master (
    output flush, if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_occ
  );

  modport slave (
    input  flush, if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_occ
  );
endinterface

// File: rtl/if_id_pipe_reg_skid.sv
// Generic valid/ready register with optional second (skid) entry and a
// synchronous flush. Output is always taken from the main entry.
module pipe_skid_buf
  import rv_pkg::*;
#(
  parameter int W       = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output pipe_st_e     state
);

  pipe_st_e     state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;
  logic         load_main;
  logic         main_from_skid;
  logic         load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaulting state_nxt first covers every path, so no latch is inferred.
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
      ST_ONE: begin
        if (!in_fire && out_fire)                state_nxt = ST_EMPTY;
        else if (in_fire && !out_fire && SKID_EN) state_nxt = ST_TWO;
      end
      ST_TWO:   if (out_fire) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // Skid mode derives ready from state alone, cutting the out_ready->in_ready path.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    if (SKID_EN) in_ready = (state != ST_TWO);
    else         in_ready = (state == ST_EMPTY) | out_ready;
  end

  // Flushed traffic never touches the data regs, so killed PCs never surface.
  assign load_main      = !flush && in_fire &&
                          ((state == ST_EMPTY) || ((state == ST_ONE) && out_fire));
  assign main_from_skid = !flush && (state == ST_TWO) && out_fire;
  assign load_skid      = !flush && (state == ST_ONE) && in_fire && !out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              main_q <= '0;
    else if (load_main)      main_q <= in_data;
    else if (main_from_skid) main_q <= skid_q;
  end

  // NOTE: skid payload is only read when state marks it valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_data;
  end

  assign out_data = main_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: packs {pc,inst} through pipe_skid_buf, masks the
// instruction to a NOP when nothing valid is held and reports occupancy.
module if_id_pipe_reg
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter bit              SKID_EN  = 1'b1,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(RV_NOP)
) (
  input logic               clk,
  input logic               rst_n,
  if_id_pipe_reg_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } pkt_t;

  pkt_t     in_pkt;
  pkt_t     out_pkt;
  pipe_st_e st;
  logic     out_valid;

  assign in_pkt = '{pc: bus.if_pc, inst: bus.if_inst};

  pipe_skid_buf #(
    .W       (XLEN + ILEN),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.if_valid),
    .in_ready  (bus.if_ready),
    .in_data   (in_pkt),
    .out_valid (out_valid),
    .out_ready (bus.id_ready),
    .out_data  (out_pkt),
    .state     (st)
  );

  // id_pc keeps its last value while empty; only the instruction is masked.
  assign bus.id_valid = out_valid;
  assign bus.id_pc    = out_pkt.pc;
  assign bus.id_inst  = out_valid ? out_pkt.inst : NOP_INST;
  assign bus.id_occ   = 2'(st);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed-vector and scoreboard bench for if_id_pipe_reg in both skid and
// combinational-ready configurations.
module tb_if_id_pipe_reg;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.XLEN(32), .ILEN(32)) b1 ();
  if_id_pipe_reg_if #(.XLEN(32), .ILEN(32)) b0 ();

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .SKID_EN(1'b1), .NOP_INST(32'h0000_0013))
    dut_skid (.clk(clk), .rst_n(rst_n), .bus(b1));
  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .SKID_EN(1'b0), .NOP_INST(32'h0000_0013))
    dut_comb (.clk(clk), .rst_n(rst_n), .bus(b0));

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t        vt[17];
  int          n_cmp = 0;
  int          n_err = 0;
  fetch_pkt_t  q0[$];
  fetch_pkt_t  q1[$];
  fetch_pkt_t  got[$];
  logic [31:0] lpc0 = '0;
  logic [31:0] lpc1 = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic fl, v, input logic [31:0] pc, input logic rdy,
                              input logic ev, er, input logic [31:0] epc, input logic [1:0] eocc);
    vec_t r;
    r.fl = fl; r.v = v; r.pc = pc; r.rdy = rdy;
    r.e_valid = ev; r.e_ready = er; r.e_pc = epc; r.e_occ = eocc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit d, input logic fl, v, input logic [31:0] pc, inst,
                       input logic rdy);
    if (d) begin
      b1.flush = fl; b1.if_valid = v; b1.id_ready = rdy;
      b1.if_pc = v ? pc : 'x; b1.if_inst = v ? inst : 'x;
    end else begin
      b0.flush = fl; b0.if_valid = v; b0.id_ready = rdy;
      b0.if_pc = v ? pc : 'x; b0.if_inst = v ? inst : 'x;
    end
  endtask

  // One cycle against the reference queue: check outputs, advance the model at the edge.
  task automatic sb_cycle(input bit d, input logic fl, v, input logic [31:0] pc, inst,
                          input logic rdy, output bit acc);
    fetch_pkt_t  q[$];
    logic [31:0] lpc;
    logic        a_valid, a_ready, e_valid, e_ready;
    logic [31:0] a_pc, a_inst, e_pc, e_inst;
    logic [1:0]  a_occ;
    bit          out_f;
    string       tag;
    if (d) begin q = q1; lpc = lpc1; end
    else   begin q = q0; lpc = lpc0; end
    drive(d, fl, v, pc, inst, rdy);
    #1;
    if (d) begin
      a_valid = b1.id_valid; a_ready = b1.if_ready; a_pc = b1.id_pc;
      a_inst = b1.id_inst; a_occ = b1.id_occ;
    end else begin
      a_valid = b0.id_valid; a_ready = b0.if_ready; a_pc = b0.id_pc;
      a_inst = b0.id_inst; a_occ = b0.id_occ;
    end
    e_valid = (q.size() != 0);
    e_pc    = e_valid ? q[0].pc : lpc;
    e_inst  = e_valid ? q[0].inst : NOP;
    e_ready = d ? (q.size() < 2) : ((q.size() == 0) || rdy);
    tag = d ? "sb_skid" : "sb_comb";
    check({tag, " id_valid"}, 32'(a_valid), 32'(e_valid));
    check({tag, " if_ready"}, 32'(a_ready), 32'(e_ready));
    check({tag, " id_pc"}, a_pc, e_pc);
    check({tag, " id_inst"}, a_inst, e_inst);
    check({tag, " id_occ"}, 32'(a_occ), 32'(q.size()));
    acc   = v && e_ready;
    out_f = e_valid && rdy;
    @(posedge clk);
    if (out_f) got.push_back(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back('{pc: pc, inst: inst});
    if (q.size() != 0) lpc = q[0].pc;
    #1;
    if (d) begin q1 = q; lpc1 = lpc; end
    else   begin q0 = q; lpc0 = lpc; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [31:0] pcn;
    logic v, fl, rdy;

    //               fl v  pc     rdy   valid ready id_pc  occ
    vt[0]  = mk(0, 1, 32'h00, 1,   1, 1, 32'h00, 2'd1);  // streaming, 1-cycle latency
    vt[1]  = mk(0, 1, 32'h04, 1,   1, 1, 32'h04, 2'd1);
    vt[2]  = mk(0, 1, 32'h08, 1,   1, 1, 32'h08, 2'd1);
    vt[3]  = mk(0, 1, 32'h0C, 1,   1, 1, 32'h0C, 2'd1);
    vt[4]  = mk(0, 0, 32'h00, 1,   0, 1, 32'h0C, 2'd0);  // drained, pc retained
    vt[5]  = mk(0, 1, 32'h10, 0,   1, 1, 32'h10, 2'd1);  // backpressure
    vt[6]  = mk(0, 1, 32'h14, 0,   1, 0, 32'h10, 2'd2);
    vt[7]  = mk(0, 1, 32'h18, 0,   1, 0, 32'h10, 2'd2);  // 0x18 refused
    vt[8]  = mk(0, 0, 32'h00, 1,   1, 1, 32'h14, 2'd1);
    vt[9]  = mk(0, 0, 32'h00, 1,   0, 1, 32'h14, 2'd0);
    vt[10] = mk(0, 1, 32'h18, 0,   1, 1, 32'h18, 2'd1);  // fill to two, then flush
    vt[11] = mk(0, 1, 32'h1C, 0,   1, 0, 32'h18, 2'd2);
    vt[12] = mk(1, 1, 32'h20, 0,   0, 1, 32'h18, 2'd0);
    vt[13] = mk(0, 1, 32'h28, 0,   1, 1, 32'h28, 2'd1);  // flush with in and out firing
    vt[14] = mk(1, 1, 32'h2C, 1,   0, 1, 32'h28, 2'd0);
    vt[15] = mk(0, 1, 32'h30, 1,   1, 1, 32'h30, 2'd1);
    vt[16] = mk(0, 0, 32'h00, 1,   0, 1, 32'h30, 2'd0);

    drive(1, 0, 0, '0, '0, 0);
    drive(0, 0, 0, '0, '0, 0);
    #12;
    check("rst id_valid", 32'(b1.id_valid), 32'd0);
    check("rst id_inst", b1.id_inst, NOP);
    check("rst id_pc", b1.id_pc, 32'd0);
    check("rst id_occ", 32'(b1.id_occ), 32'd0);
    check("rst if_ready", 32'(b1.if_ready), 32'd1);
    check("rst comb if_ready", 32'(b0.if_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 17; i++) begin
      drive(1, vt[i].fl, vt[i].v, vt[i].pc, inst_of(vt[i].pc), vt[i].rdy);
      @(posedge clk); #2;
      check($sformatf("vec%0d id_valid", i), 32'(b1.id_valid), 32'(vt[i].e_valid));
      check($sformatf("vec%0d if_ready", i), 32'(b1.if_ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d id_pc", i), b1.id_pc, vt[i].e_pc);
      check($sformatf("vec%0d id_inst", i), b1.id_inst,
            vt[i].e_valid ? inst_of(vt[i].e_pc) : NOP);
      check($sformatf("vec%0d id_occ", i), 32'(b1.id_occ), 32'(vt[i].e_occ));
    end

    // Reset asserted mid-stream with two entries held.
    drive(1, 0, 1, 32'h40, inst_of(32'h40), 0);
    @(posedge clk); #2;
    drive(1, 0, 1, 32'h44, inst_of(32'h44), 0);
    @(posedge clk); #2;
    check("midrst pre occ", 32'(b1.id_occ), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst id_valid", 32'(b1.id_valid), 32'd0);
    check("midrst id_inst", b1.id_inst, NOP);
    check("midrst id_occ", 32'(b1.id_occ), 32'd0);
    check("midrst if_ready", 32'(b1.if_ready), 32'd1);
    check("midrst id_pc", b1.id_pc, 32'd0);
    @(posedge clk); #2;
    check("midrst held occ", 32'(b1.id_occ), 32'd0);
    drive(1, 0, 0, '0, '0, 0);
    @(negedge clk) rst_n = 1'b1;
    q0.delete(); q1.delete(); lpc0 = '0; lpc1 = '0;
    @(posedge clk); #1;

    // Combinational-ready config: id_ready toggling, 0x100..0x11C in order.
    got.delete();
    pcn = 32'h100;
    for (int c = 0; c < 64 && got.size() < 8; c++) begin
      v = (pcn <= 32'h11C);
      sb_cycle(1'b0, 1'b0, v, pcn, inst_of(pcn), (c % 2) == 0, acc);
      if (acc) pcn += 4;
    end
    check("comb delivered", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("comb order%0d", i), got[i].pc, 32'h100 + 32'(4 * i));

    // Random valid/ready/flush against the reference queue, both configs.
    for (int d = 1; d >= 0; d--) begin
      pcn = 32'h1000;
      for (int c = 0; c < 4500; c++) begin
        v   = ($urandom_range(0, 9) < 7);
        fl  = ($urandom_range(0, 19) == 0);
        rdy = ($urandom_range(0, 9) < 6);
        sb_cycle(d == 1, fl, v, pcn, $urandom, rdy, acc);
        if (acc) pcn += 4;
      end
      for (int c = 0; c < 3; c++) sb_cycle(d == 1, 1'b0, 1'b0, '0, '0, 1'b1, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
